rx_sample_timer: RTL and testbench

RX_SAMPLE_TIMER -- requirements
Module: rx_sample_timer

---
 rtl/rx_sample_timer.sv | 103 ++++++++++
 tb/tb_rx_sample_timer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sample_timer.sv
// USB receive bit-sampling timer: tracks the phase within each bit period, resynchronises on
// line transitions, and emits sample, shift and byte-complete strobes while a packet is received.
`timescale 1ns/1ps

module rx_sample_timer #(
  parameter  int CLKS_PER_BIT  = 8,
  parameter  int SAMPLE_PHASE  = 3,
  parameter  int BITS_PER_BYTE = 8,
  localparam int PW            = $clog2(CLKS_PER_BIT),
  localparam int BW            = $clog2(BITS_PER_BYTE)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          enable_timer,
  input  logic          line_edge,
  input  logic          stuff_bit,
  input  logic          eop_detected,
  output logic          sample_strobe,
  output logic          shift_enable,
  output logic          byte_complete,
  output logic [BW-1:0] bit_count,
  output logic          active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PHASE);
  localparam logic [BW-1:0] BIT_LAST     = BW'(BITS_PER_BYTE - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_next;
  logic [BW-1:0] r_bit_count;
  logic [BW-1:0] w_bit_count_next;
  logic          r_active;
  logic          w_run;
  logic          w_stay_run;

  assign w_run      = (r_state == S_RUN);
  assign w_stay_run = w_run && (w_next_state == S_RUN);

  // NOTE: every signal driven from always_comb gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (enable_timer && !eop_detected) w_next_state = S_RUN;
      S_RUN: begin
        if (eop_detected)       w_next_state = S_HOLD;
        else if (!enable_timer) w_next_state = S_IDLE;
      end
      S_HOLD: if (!enable_timer) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Strobes come from the current phase; eop or a dropped enable gate them in the same cycle.
  assign sample_strobe = w_run && enable_timer && !eop_detected && (r_phase == PHASE_SAMPLE);
  assign shift_enable  = sample_strobe && !stuff_bit;
  assign byte_complete = shift_enable && (r_bit_count == BIT_LAST);

  // Phase is parked at 0 outside RUN, so the first RUN cycle always starts at phase 0.
  always_comb begin
    w_phase_next = '0;
    if (w_stay_run && !line_edge && (r_phase != PHASE_LAST)) begin
      w_phase_next = r_phase + PW'(1);
    end
  end

  // Leaving RUN discards any partial byte.
  always_comb begin
    w_bit_count_next = r_bit_count;
    if (!w_stay_run) begin
      w_bit_count_next = '0;
    end else if (shift_enable) begin
      w_bit_count_next = (r_bit_count == BIT_LAST) ? '0 : r_bit_count + BW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_bit_count <= '0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_phase     <= w_phase_next;
      r_bit_count <= w_bit_count_next;
      r_active    <= (w_next_state == S_RUN);
    end
  end

  assign bit_count = r_bit_count;
  assign active    = r_active;

endmodule

// File: tb/tb_rx_sample_timer.sv
// Directed bench for rx_sample_timer: free-run, resync, stuffing, EOP/HOLD, async reset,
// and an alternate-parameter instance (4 clocks/bit, sample phase 1, 16-bit bytes).
`timescale 1ns/1ps

module tb_rx_sample_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       enable_timer, line_edge, stuff_bit, eop_detected;
  logic       sample_strobe, shift_enable, byte_complete, active;
  logic [2:0] bit_count;

  logic       a_en;
  logic       a_zero = 1'b0;
  logic       a_strobe, a_shift, a_done, a_active;
  logic [3:0] a_bit_count;

  int checks = 0;
  int errors = 0;

  rx_sample_timer u_dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .line_edge    (line_edge),
    .stuff_bit    (stuff_bit),
    .eop_detected (eop_detected),
    .sample_strobe(sample_strobe),
    .shift_enable (shift_enable),
    .byte_complete(byte_complete),
    .bit_count    (bit_count),
    .active       (active)
  );

  rx_sample_timer #(
    .CLKS_PER_BIT (4),
    .SAMPLE_PHASE (1),
    .BITS_PER_BYTE(16)
  ) u_alt (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (a_en),
    .line_edge    (a_zero),
    .stuff_bit    (a_zero),
    .eop_detected (a_zero),
    .sample_strobe(a_strobe),
    .shift_enable (a_shift),
    .byte_complete(a_done),
    .bit_count    (a_bit_count),
    .active       (a_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    enable_timer = 1'b0;
    line_edge    = 1'b0;
    stuff_bit    = 1'b0;
    eop_detected = 1'b0;
  endtask

  // Leaves the bench mid-cycle in IDLE with reset released.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Leaves the bench mid-cycle in RUN cycle 0.
  task automatic start_run();
    enable_timer = 1'b1;
    @(negedge clk);
  endtask

  // Checks a run with no resync; stuff_n is the RUN cycle carrying a stuffed bit (-1 for none).
  task automatic run_bytes(input string name, input int ncyc, input int stuff_n);
    for (int n = 0; n < ncyc; n++) begin
      int  shifted;
      int  exp_bc;
      logic exp_strobe, exp_shift;
      if (n > 0) @(negedge clk);
      stuff_bit = (n == stuff_n);
      #1;
      exp_strobe = (n % 8 == 3);
      shifted    = (n + 4) / 8 - ((stuff_n >= 0 && n > stuff_n) ? 1 : 0);
      exp_bc     = shifted % 8;
      exp_shift  = exp_strobe && (n != stuff_n);
      check($sformatf("%s strobe c%0d", name, n), sample_strobe, exp_strobe);
      check($sformatf("%s shift c%0d", name, n), shift_enable, exp_shift);
      check($sformatf("%s byte c%0d", name, n), byte_complete, exp_shift && exp_bc == 7);
      check($sformatf("%s bit_count c%0d", name, n), bit_count, exp_bc);
      check($sformatf("%s active c%0d", name, n), active, 1);
    end
    stuff_bit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    a_en  = 1'b0;
    idle_inputs();
    enable_timer = 1'b1;
    #12;
    check("reset strobe", sample_strobe, 0);
    check("reset shift", shift_enable, 0);
    check("reset byte", byte_complete, 0);
    check("reset bit_count", bit_count, 0);
    check("reset active", active, 0);

    // Free-run from RUN cycle 0: strobes at 3, 11, ... 59; byte at 59.
    do_reset();
    start_run();
    run_bytes("free", 64, -1);

    // Resync at phase 6 (cycle 6): strobes at 3, 10, 18 only.
    do_reset();
    start_run();
    for (int n = 0; n <= 20; n++) begin
      if (n > 0) @(negedge clk);
      line_edge = (n == 6);
      #1;
      check($sformatf("resync strobe c%0d", n), sample_strobe, (n == 3 || n == 10 || n == 18));
      if (n == 10) check("resync bit_count c10", bit_count, 1);
      if (n == 18) check("resync bit_count c18", bit_count, 2);
    end
    line_edge = 1'b0;

    // Edge coinciding with the sample phase: strobe fires, then 4 cycles to the next.
    do_reset();
    start_run();
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) @(negedge clk);
      line_edge = (n == 3);
      #1;
      check($sformatf("edge_at_sample strobe c%0d", n), sample_strobe, (n == 3 || n == 7 || n == 15));
    end
    line_edge = 1'b0;

    // Stuffed 4th bit (cycle 27): byte completes on the 9th strobe at cycle 67.
    do_reset();
    start_run();
    run_bytes("stuff", 72, 27);

    // EOP on the 6th strobe (bit_count 5), HOLD, then re-enable.
    do_reset();
    start_run();
    for (int n = 0; n <= 43; n++) begin
      if (n > 0) @(negedge clk);
      eop_detected = (n == 43);
      #1;
    end
    check("eop bit_count before", bit_count, 5);
    check("eop strobe", sample_strobe, 0);
    check("eop shift", shift_enable, 0);
    check("eop byte", byte_complete, 0);
    @(negedge clk);
    eop_detected = 1'b0;
    #1;
    check("hold active", active, 0);
    check("hold bit_count", bit_count, 0);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      line_edge = (n == 4);
      stuff_bit = 1'b1;
      #1;
      check($sformatf("hold strobe h%0d", n), sample_strobe, 0);
      check($sformatf("hold active h%0d", n), active, 0);
      check($sformatf("hold bit_count h%0d", n), bit_count, 0);
    end
    line_edge = 1'b0;
    stuff_bit = 1'b0;
    @(negedge clk);
    enable_timer = 1'b0;
    #1;
    check("hold exit active", active, 0);
    @(negedge clk);
    enable_timer = 1'b1;
    #1;
    check("idle active", active, 0);
    check("idle strobe", sample_strobe, 0);
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      #1;
      check($sformatf("rerun active c%0d", n), active, 1);
      check($sformatf("rerun strobe c%0d", n), sample_strobe, (n == 3));
    end

    // Async reset mid-byte on a strobe cycle, then a clean restart.
    do_reset();
    start_run();
    for (int n = 0; n <= 11; n++) begin
      if (n > 0) @(negedge clk);
      #1;
    end
    check("pre_reset strobe", sample_strobe, 1);
    check("pre_reset bit_count", bit_count, 1);
    #1;
    n_rst = 1'b0;
    #1;
    check("async strobe", sample_strobe, 0);
    check("async shift", shift_enable, 0);
    check("async byte", byte_complete, 0);
    check("async bit_count", bit_count, 0);
    check("async active", active, 0);
    @(negedge clk);
    #1;
    check("in_reset active", active, 0);
    check("in_reset strobe", sample_strobe, 0);
    n_rst = 1'b1;
    @(negedge clk);
    run_bytes("restart", 64, -1);

    // Alternate parameters: strobe every 4 cycles at phase 1, byte on the 16th shift.
    do_reset();
    a_en = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 67; n++) begin
      int   a_exp_bc;
      logic a_exp_strobe;
      if (n > 0) @(negedge clk);
      #1;
      a_exp_strobe = (n % 4 == 1);
      a_exp_bc     = ((n + 2) / 4) % 16;
      check($sformatf("alt strobe c%0d", n), a_strobe, a_exp_strobe);
      check($sformatf("alt shift c%0d", n), a_shift, a_exp_strobe);
      check($sformatf("alt byte c%0d", n), a_done, a_exp_strobe && a_exp_bc == 15);
      check($sformatf("alt bit_count c%0d", n), a_bit_count, a_exp_bc);
      check($sformatf("alt active c%0d", n), a_active, 1);
    end
    a_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
